// File: rtl/cpu_pc_pkg.sv
// rtl/cpu_pc_pkg.sv - shared program-counter types, widths and reset vector defaults
package cpu_pc_pkg;

  localparam int PC_BYTE_W = 8;

  typedef logic [PC_BYTE_W-1:0] pc_byte_t;

  localparam pc_byte_t RESET_PCL_DEFAULT = 8'h00;
  localparam pc_byte_t RESET_PCH_DEFAULT = 8'h00;

  typedef enum logic {
    NO_CARRY = 1'b0,
    CARRY    = 1'b1
  } carry_state_e;

endpackage

// File: rtl/program_counter_increment_unit_if.sv
// rtl/program_counter_increment_unit_if.sv - select-register inputs and PC bus outputs of the increment unit
interface program_counter_increment_unit_if;
  import cpu_pc_pkg::*;

  pc_byte_t pcls;
  pc_byte_t pchs;
  logic     inc_pc;
  logic     load_pcl;
  logic     load_pch;
  pc_byte_t pcl;
  pc_byte_t pch;
  logic     carry_pending;
  logic     pc_wrap;

  modport master (
    output pcls, pchs, inc_pc, load_pcl, load_pch,
    input  pcl, pch, carry_pending, pc_wrap
  );

  modport slave (
    input  pcls, pchs, inc_pc, load_pcl, load_pch,
    output pcl, pch, carry_pending, pc_wrap
  );

endinterface

// File: rtl/program_counter_increment_unit_byte_incrementer.sv
// rtl/program_counter_increment_unit_byte_incrementer.sv - combinational 8-bit add of a single increment bit
module byte_incrementer
  import cpu_pc_pkg::*;
(
  input  pc_byte_t a_i,
  input  logic     inc_i,
  output pc_byte_t sum_o,
  output logic     carry_o
);

  logic [PC_BYTE_W:0] full_sum;

  // The ninth bit of the add is the carry out of the byte.
  assign full_sum = {1'b0, a_i} + {{PC_BYTE_W{1'b0}}, inc_i};
  assign sum_o    = full_sum[PC_BYTE_W-1:0];
  assign carry_o  = full_sum[PC_BYTE_W];

endmodule

// File: rtl/program_counter_increment_unit.sv
// rtl/program_counter_increment_unit.sv - PCL/PCH registers with a one-cycle delayed low-to-high carry
module program_counter_increment_unit
  import cpu_pc_pkg::*;
#(
  parameter pc_byte_t RESET_PCL = RESET_PCL_DEFAULT,
  parameter pc_byte_t RESET_PCH = RESET_PCH_DEFAULT
) (
  input  logic                                clk,
  input  logic                                reset,
  program_counter_increment_unit_if.slave     pc_bus
);

  pc_byte_t     pcl_q, pcl_d;
  pc_byte_t     pch_q, pch_d;
  logic         pc_wrap_q, pc_wrap_d;
  carry_state_e state_q, state_d;

  pc_byte_t     lo_sum;
  logic         lo_carry;
  pc_byte_t     hi_sum;
  logic         hi_carry;
  logic         carry_pending;

  assign carry_pending = (state_q == CARRY);

  byte_incrementer u_lo_inc (
    .a_i     (pc_bus.pcls),
    .inc_i   (pc_bus.inc_pc),
    .sum_o   (lo_sum),
    .carry_o (lo_carry)
  );

  byte_incrementer u_hi_inc (
    .a_i     (pc_bus.pchs),
    .inc_i   (carry_pending),
    .sum_o   (hi_sum),
    .carry_o (hi_carry)
  );

  always_comb begin
    pcl_d     = pcl_q;
    pch_d     = pch_q;
    pc_wrap_d = 1'b0;
    state_d   = state_q;

    if (pc_bus.load_pcl) begin
      pcl_d = lo_sum;
    end

    // PCH always sees the carry from before this edge, even when PCL loads too.
    if (pc_bus.load_pch) begin
      pch_d     = hi_sum;
      pc_wrap_d = hi_carry;
    end

    case (state_q)
      NO_CARRY: begin
        if (pc_bus.load_pcl && lo_carry) begin
          state_d = CARRY;
        end
      end
      CARRY: begin
        // A fresh low byte supersedes whatever carry was still waiting.
        if (pc_bus.load_pcl) begin
          state_d = lo_carry ? CARRY : NO_CARRY;
        end else if (pc_bus.load_pch) begin
          state_d = NO_CARRY;
        end
      end
      default: state_d = NO_CARRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcl_q     <= RESET_PCL;
      pch_q     <= RESET_PCH;
      pc_wrap_q <= 1'b0;
      state_q   <= NO_CARRY;
    end else begin
      pcl_q     <= pcl_d;
      pch_q     <= pch_d;
      pc_wrap_q <= pc_wrap_d;
      state_q   <= state_d;
    end
  end

  assign pc_bus.pcl           = pcl_q;
  assign pc_bus.pch           = pch_q;
  assign pc_bus.carry_pending = carry_pending;
  assign pc_bus.pc_wrap       = pc_wrap_q;

endmodule

// File: doc/program_counter_increment_unit.md
Name: program_counter_increment_unit

Overview:
- Sits directly downstream of the PCL and PCH select registers.
- Takes the selected low and high program-counter bytes, increments them, and holds the results in the PCL and PCH registers. Those registers drive the PC buses that feed back into the select registers.
- Carry from low byte to high byte is delayed by one cycle, 6502-style. An address crossing a page boundary therefore fixes up its high byte on the next PCH load.

Parameters:
- RESET_PCL, 8'h00, PCL value after reset.
- RESET_PCH, 8'h00, PCH value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- pcls  input  8  selected low byte from the PCL select register
- pchs  input  8  selected high byte from the PCH select register
- inc_pc  input  1  increment request applied to the low byte
- load_pcl  input  1  write incremented low byte into PCL
- load_pch  input  1  write high byte plus pending carry into PCH
- pcl  output  8  PCL register, drives the low PC bus
- pch  output  8  PCH register, drives the high PC bus
- carry_pending  output  1  low-byte carry latched and not yet consumed by PCH
- pc_wrap  output  1  one-cycle pulse: PCH wrapped FF->00 on the previous edge

Behaviour:
- Single clock, synchronous active-high reset. Reset has priority over all other inputs.
- Reset values: pcl=RESET_PCL, pch=RESET_PCH, carry_pending=0, pc_wrap=0.
- Low byte, on a rising edge with load_pcl=1:
  - pcl <= (pcls + inc_pc) mod 256.
  - The carry flag is set to inc_pc & (pcls==8'hFF).
  - With load_pcl=1 and inc_pc=0, pcl <= pcls and the carry flag is set to 0.
- High byte, on a rising edge with load_pch=1:
  - pch <= (pchs + carry_pending) mod 256, using the carry value from before the edge.
  - pc_wrap <= carry_pending & (pchs==8'hFF). pc_wrap is 0 on every other edge.
- Carry state machine (the carry_pending register):
  - State NO_CARRY: go to CARRY on load_pcl with a generated carry. Otherwise stay.
  - State CARRY, load_pch=1 and no new carry: go to NO_CARRY.
  - State CARRY, load_pch=1 and load_pcl generating a new carry on the same edge: stay in CARRY.
  - State CARRY, load_pcl=1 with no carry generated and load_pch=0: go to NO_CARRY. The pending carry is discarded, because the new low byte supersedes it.
  - State CARRY, no loads: hold indefinitely.
- Simultaneous load_pcl and load_pch: PCH consumes the old carry. PCL produces the new carry. Both updates happen on the same edge.
- inc_pc without load_pcl has no effect. No state changes.
- Latency: outputs are registered and visible one cycle after the load edge. There is no combinational path from inputs to outputs.
- Reset mid-operation: a pending carry is dropped and no pc_wrap pulse is emitted.
- Widths: all byte arithmetic is 8-bit modulo. The carry is the 9th bit of the low-byte add.

Decomposition:
- Shared package cpu_pc_pkg holds:
  - PC_BYTE_W=8;
  - a byte typedef;
  - the reset-vector default constants, used as the parameter defaults.
- One natural sub-module: byte_incrementer.
  - Combinational: 8-bit in, 1-bit inc, 8-bit sum, carry out.
  - Instantiated twice: once for the low byte with inc=inc_pc, once for the high byte with inc=carry_pending.

Test Plan:
- Reset: assert reset for 2 cycles with any inputs -> pcl=00, pch=00, carry_pending=0, pc_wrap=0.
- Plain increment: pcls=34, inc_pc=1, load_pcl=1 -> next cycle pcl=35, carry_pending=0. Then pchs=12, load_pch=1 -> pch=12.
- Page crossing:
  - Edge 1: pcls=FF, inc_pc=1, load_pcl=1 -> pcl=00, carry_pending=1.
  - Edge 2: pchs=12, load_pch=1 -> pch=13, carry_pending=0.
- Full wrap:
  - Edge 1: pcls=FF, inc_pc=1, load_pcl -> carry_pending=1.
  - Edge 2: pchs=FF, load_pch -> pch=00, pc_wrap=1 for exactly one cycle.
- Simultaneous loads:
  - Start with carry_pending=1.
  - Drive pcls=FF, inc_pc=1, pchs=40, both loads high -> pch=41, pcl=00, carry_pending remains 1.
- Discard and hold:
  - Start with carry_pending=1, then idle for 5 cycles -> carry_pending stays 1.
  - Then load_pcl with pcls=10, inc_pc=0 -> pcl=10, carry_pending=0.
  - Then load_pch with pchs=20 -> pch=20.
  - Repeat from carry_pending=1, asserting reset -> carry_pending=0 and no pc_wrap pulse.
